// File: rtl/whirlpool_core.sv
// Whirlpool compression function: H' = W_H(m) ^ m ^ H, one cipher round per clock.
// Define WHIRL_SBOX_LOGIC_EN to build the S-box from the E/E^-1/R mini-boxes instead of a table.
module whirlpool_core (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [511:0] i_data,
    input  logic [511:0] i_vin,
    output logic [511:0] o_vout,
    output logic         o_done
);

    typedef enum logic [0:0] {StIdle, StRound} fsm_e;

    localparam logic [3:0]  LAST_ROUND = 4'd10;
    // Theta circulant row (01,01,04,01,08,05,02,09), one nibble per coefficient
    localparam logic [31:0] THETA_C    = 32'h1141_8529;

`ifdef WHIRL_SBOX_LOGIC_EN
    localparam logic [63:0] MINI_E  = 64'h1B9C_D6F3_E874_A250;
    localparam logic [63:0] MINI_EI = 64'hF0D7_BE5A_92C1_3486;
    localparam logic [63:0] MINI_R  = 64'h7CBD_E49F_638A_2510;

    function automatic logic [3:0] nib(input logic [63:0] tab, input logic [3:0] x);
        return tab[{~x, 2'b11} -: 4];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] u;
        logic [3:0] l;
        logic [3:0] r;
        u = nib(MINI_E, x[7:4]);
        l = nib(MINI_EI, x[3:0]);
        r = nib(MINI_R, u ^ l);
        return {nib(MINI_E, u ^ r), nib(MINI_EI, l ^ r)};
    endfunction
`else
    localparam logic [2047:0] SBOX_TABLE = {
        128'h1823C6E887B8014F36A6D2F5796F9152,
        128'h60BC9B8EA30C7B351DE0D7C22E4BFE57,
        128'h157737E59FF04ADA58C9290AB1A06B85,
        128'hBD5D10F4CB3E0567E427418BA77D95D8,
        128'hFBEE7C66DD17479ECA2DBF07AD5A8333,
        128'h6302AA71C81949D9F2E35B889A2632B0,
        128'hE90FD580BECD3448FF7A905F20681AAE,
        128'hB454932264F173124008C3ECDBA18D3D,
        128'h9700CF2B7682D61BB5AF6A5045F330EF,
        128'h3F55A2EA65BA2FC0DE1CFD4D9275068A,
        128'hB2E60E1F62D4A896F9C525598472394C,
        128'h5E78388CD1A5E261B3219C1E43C7FC04,
        128'h51996D0DFADF7E243BABCE118F4EB7EB,
        128'h3C8194F7B9132CD3E76EC40356447FA9,
        128'h2ABBC153DC0B9D6C3174F646AC8914E1,
        128'h163A690970B6D0EDCC4298A4285CF886
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction
`endif

    // MSB of byte (row, col) in a 512-bit vector; byte 0 sits at [511:504]
    function automatic logic [8:0] bpos(input logic [2:0] row, input logic [2:0] col);
        return {~row, ~col, 3'b111};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int b = 0; b < 4; b++) begin
            if (c[b]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [511:0] rho(input logic [511:0] a, input logic [511:0] k);
        logic [511:0] g;
        logic [511:0] p;
        logic [511:0] t;
        logic [7:0]   acc;
        logic [2:0]   src;
        logic [2:0]   cidx;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                g[bpos(3'(i), 3'(j)) -: 8] = sbox(a[bpos(3'(i), 3'(j)) -: 8]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                src = 3'(i) - 3'(j);
                p[bpos(3'(i), 3'(j)) -: 8] = g[bpos(src, 3'(j)) -: 8];
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = 8'h00;
                for (int tt = 0; tt < 8; tt++) begin
                    cidx = 3'(j) - 3'(tt);
                    acc  = acc ^ gf_mul(p[bpos(3'(i), 3'(tt)) -: 8], THETA_C[{~cidx, 2'b11} -: 4]);
                end
                t[bpos(3'(i), 3'(j)) -: 8] = acc;
            end
        end
        return t ^ k;
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [511:0] key_q, key_d;
    logic [511:0] state_q, state_d;
    logic [511:0] ff_q, ff_d;
    logic [511:0] vout_q, vout_d;
    logic         done_q, done_d;

    logic [511:0] round_const;
    logic [511:0] key_next;
    logic [511:0] state_next;

    // Row 0 of c_r is SBOX[8(r-1) .. 8(r-1)+7]; the other rows are zero
    always_comb begin
        round_const = '0;
        for (int j = 0; j < 8; j++) begin
            round_const[bpos(3'd0, 3'(j)) -: 8] = sbox({1'b0, round_q - 4'd1, 3'(j)});
        end
    end

    assign key_next   = rho(key_q, round_const);
    assign state_next = rho(state_q, key_next);

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        key_d   = key_q;
        state_d = state_q;
        ff_d    = ff_q;
        vout_d  = vout_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (i_start) begin
                    key_d   = i_vin;
                    state_d = i_data ^ i_vin;
                    ff_d    = i_data ^ i_vin;
                    round_d = 4'd1;
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                key_d   = key_next;
                state_d = state_next;
                round_d = round_q + 4'd1;
                if (round_q == LAST_ROUND) begin
                    vout_d  = state_next ^ ff_q;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q   <= StIdle;
            round_q <= 4'd0;
            key_q   <= '0;
            state_q <= '0;
            ff_q    <= '0;
            vout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            key_q   <= key_d;
            state_q <= state_d;
            ff_q    <= ff_d;
            vout_q  <= vout_d;
            done_q  <= done_d;
        end
    end

    assign o_vout = vout_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_whirlpool_core.sv
// Bench for whirlpool_core: known digests, chained blocks and random blocks against a
// byte-matrix Whirlpool model whose S-box is derived from the mini-box construction.
module tb_whirlpool_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [511:0] data;
    logic [511:0] vin;
    logic [511:0] vout;
    logic         done;

    always #5 clk = ~clk;

    whirlpool_core dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_data (data),
        .i_vin  (vin),
        .o_vout (vout),
        .o_done (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [511:0] EMPTY_BLOCK  = {8'h80, 504'd0};
    localparam logic [511:0] ABC_BLOCK    = {32'h61626380, 472'd0, 8'h18};
    localparam logic [511:0] EMPTY_DIGEST = 512'h19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3;
    localparam logic [511:0] ABC_DIGEST   = 512'h4E2448A4C6F486BB16B6562C73B4020BF3043E3A731BCE721AE1B303D97E6D4C7181EEBDB6C57E277D0E34957114CBD6C797FC9D95D8B582D225292076D4EEF5;

    localparam logic [3:0] E_BOX  [16] = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
                                           4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
    localparam logic [3:0] EI_BOX [16] = '{4'hF, 4'h0, 4'hD, 4'h7, 4'hB, 4'hE, 4'h5, 4'hA,
                                           4'h9, 4'h2, 4'hC, 4'h1, 4'h3, 4'h4, 4'h8, 4'h6};
    localparam logic [3:0] R_BOX  [16] = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
                                           4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};
    localparam logic [7:0] THETA  [8]  = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};

    logic [7:0] sbox_tab [256];

    task automatic build_sbox();
        logic [3:0] u;
        logic [3:0] l;
        logic [3:0] r;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            u  = E_BOX[xb[7:4]];
            l  = EI_BOX[xb[3:0]];
            r  = R_BOX[u ^ l];
            sbox_tab[x] = {E_BOX[u ^ r], EI_BOX[l ^ r]};
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [511:0] ref_round(input logic [511:0] av, input logic [511:0] kv);
        logic [7:0]   a [8][8];
        logic [7:0]   b [8][8];
        logic [7:0]   acc;
        logic [511:0] r;
        for (int n = 0; n < 64; n++) a[n / 8][n % 8] = sbox_tab[av[511 - 8 * n -: 8]];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) b[i][j] = a[(i - j + 8) % 8][j];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = 8'h00;
                for (int t = 0; t < 8; t++) acc = acc ^ gmul(b[i][t], THETA[(j - t + 8) % 8]);
                r[511 - 8 * (8 * i + j) -: 8] = acc ^ kv[511 - 8 * (8 * i + j) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [511:0] ref_compress(input logic [511:0] h, input logic [511:0] m);
        logic [511:0] k;
        logic [511:0] s;
        logic [511:0] rc;
        k = h;
        s = m ^ h;
        for (int r = 1; r <= 10; r++) begin
            rc = '0;
            for (int j = 0; j < 8; j++) rc[511 - 8 * j -: 8] = sbox_tab[8 * (r - 1) + j];
            k = ref_round(k, rc);
            s = ref_round(s, k);
        end
        return s ^ m ^ h;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32 * i +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Starts one block and waits (bounded) for o_done; lat = 40 means no done arrived.
    task automatic run_block(input logic [511:0] m, input logic [511:0] h,
                             output logic [511:0] res, output int lat);
        start = 1'b1;
        data  = m;
        vin   = h;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = vout;
    endtask

    task automatic test_reset();
        int extra;
        data = rand512();
        vin  = rand512();
        do_reset();
        n_cmp++;
        if (vout !== 512'd0) begin
            n_bad++;
            $display("FAIL reset_vout: got %h, want 0", vout);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done: got %b, want 0", done);
        end
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL reset_idle_done: got %0d pulses, want 0", extra);
        end
    endtask

    task automatic test_empty();
        logic [511:0] res;
        int           lat;
        run_block(EMPTY_BLOCK, 512'd0, res, lat);
        n_cmp++;
        if (lat !== 10) begin
            n_bad++;
            $display("FAIL empty_latency: got %0d, want 10", lat);
        end
        n_cmp++;
        if (res !== EMPTY_DIGEST) begin
            n_bad++;
            $display("FAIL empty_digest: got %h, want %h", res, EMPTY_DIGEST);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_done_pulse: got %b, want 0", done);
        end
    endtask

    task automatic test_abc();
        logic [511:0] res;
        int           lat;
        run_block(ABC_BLOCK, 512'd0, res, lat);
        n_cmp++;
        if (res !== ABC_DIGEST || lat !== 10) begin
            n_bad++;
            $display("FAIL abc_digest: got %h lat %0d, want %h lat 10", res, lat, ABC_DIGEST);
        end
    endtask

    task automatic test_chain_a3();
        logic [511:0] blk4;
        logic [511:0] m;
        logic [511:0] h_model;
        logic [511:0] h_dut;
        logic [511:0] exp;
        logic [511:0] res;
        int           lat;
        blk4            = '0;
        blk4[511:448]   = {8{8'hA3}};
        blk4[447:440]   = 8'h80;
        blk4[15:0]      = 16'h0640;
        h_model         = '0;
        h_dut           = '0;
        for (int b = 0; b < 4; b++) begin
            m   = (b < 3) ? {64{8'hA3}} : blk4;
            exp = ref_compress(h_model, m);
            run_block(m, h_dut, res, lat);
            n_cmp++;
            if (res !== exp || lat !== 10) begin
                n_bad++;
                $display("FAIL a3_block%0d: got %h lat %0d, want %h lat 10", b, res, lat, exp);
            end
            h_model = exp;
            h_dut   = res;
        end
    endtask

    task automatic test_random();
        logic [511:0] m;
        logic [511:0] h;
        logic [511:0] exp;
        logic [511:0] res;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            m   = rand512();
            h   = rand512();
            exp = ref_compress(h, m);
            run_block(m, h, res, lat);
            n_cmp++;
            if (res !== exp || lat !== 10) begin
                n_bad++;
                $display("FAIL random%0d: got %h lat %0d, want %h lat 10", i, res, lat, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] m;
        logic [511:0] h_model;
        logic [511:0] exp;
        logic [511:0] res;
        int           lat;
        h_model = rand512();
        m       = rand512();
        exp     = ref_compress(h_model, m);
        run_block(m, h_model, res, lat);
        h_model = exp;
        for (int i = 0; i < 3; i++) begin
            m   = rand512();
            exp = ref_compress(h_model, m);
            // Next start issued in the done cycle, chaining value taken straight off o_vout
            run_block(m, vout, res, lat);
            n_cmp++;
            if (res !== exp || lat !== 10) begin
                n_bad++;
                $display("FAIL b2b%0d: got %h lat %0d, want %h lat 10", i, res, lat, exp);
            end
            h_model = exp;
        end
    endtask

    task automatic test_start_busy();
        logic [511:0] m0;
        logic [511:0] h0;
        logic [511:0] exp;
        logic [511:0] got;
        int           ndone;
        m0    = rand512();
        h0    = rand512();
        exp   = ref_compress(h0, m0);
        got   = '0;
        ndone = 0;
        start = 1'b1;
        data  = m0;
        vin   = h0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 10; k++) begin
            start = 1'b1;
            data  = rand512();
            vin   = rand512();
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                got = vout;
            end
        end
        start = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_bad++;
            $display("FAIL busy_done_count: got %0d, want 1", ndone);
        end
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL busy_result: got %h, want %h", got, exp);
        end
        n_cmp++;
        if (vout !== exp) begin
            n_bad++;
            $display("FAIL busy_hold: got %h, want %h", vout, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] res;
        int           lat;
        int           ndone;
        start = 1'b1;
        data  = EMPTY_BLOCK;
        vin   = 512'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (vout !== 512'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: got vout %h done %b, want 0 and 0", vout, done);
        end
        ndone = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL midreset_no_done: got %0d pulses, want 0", ndone);
        end
        run_block(EMPTY_BLOCK, 512'd0, res, lat);
        n_cmp++;
        if (res !== EMPTY_DIGEST || lat !== 10) begin
            n_bad++;
            $display("FAIL midreset_restart: got %h lat %0d, want %h lat 10", res, lat, EMPTY_DIGEST);
        end
    endtask

    task automatic test_hold();
        logic [511:0] m;
        logic [511:0] h;
        logic [511:0] exp;
        logic [511:0] res;
        int           lat;
        m   = rand512();
        h   = rand512();
        exp = ref_compress(h, m);
        run_block(m, h, res, lat);
        for (int c = 0; c < 50; c++) begin
            data = rand512();
            vin  = rand512();
            @(posedge clk);
            #1;
            n_cmp++;
            if (vout !== exp || done !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got %h done %b, want %h done 0", c, vout, done, exp);
            end
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        data  = '0;
        vin   = '0;
        build_sbox();
        test_reset();
        test_empty();
        test_abc();
        test_chain_a3();
        test_random();
        test_back_to_back();
        test_start_busy();
        test_reset_mid();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
